fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Next-generation instruction fetch stage: decouples the PC generator from instruction memory
//  with a parametrised prefetch queue and a variable-latency, in-order imem request/response port.
//  Sits between imem and decode. Handles branch, interrupt, RTI/RSI redirects and decode
//  back-pressure through a valid/ready handshake. Adds single-level interrupt masking.
// PARAMETERS
//  XLEN       32            address/instruction width
//  DEPTH      4             prefetch queue entries and max outstanding requests; power of 2, >=2
//  RESET_VEC  32'h00000000  PC after reset
//  IRQ_VEC    32'h00000004  interrupt handler entry PC
//  NOP_INSTR  32'h00000013  addi x0,x0,0, driven on dec_instr whenever dec_valid=0
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     asynchronous active-low reset
//  imem_req      out  1     issue fetch at imem_addr this cycle
//  imem_addr     out  XLEN  fetch address, word aligned
//  imem_rvalid   in   1     response valid, in request order, >=1 cycle after its request
//  imem_rdata    in   XLEN  response instruction
//  branch        in   1     redirect to branch_target (resolved in EX)
//  branch_target in   XLEN  branch destination
//  interrupt     in   1     interrupt request
//  rti           in   1     return from interrupt: redirect to epc
//  rsi           in   1     interrupt handled: clear epc and in_irq, no redirect
//  dec_ready     in   1     decode accepts (low = stall)
//  dec_valid     out  1     dec_instr/dec_pc valid
//  dec_instr     out  XLEN  instruction to decode
//  dec_pc        out  XLEN  PC of dec_instr
//  dec_pc_next   out  XLEN  dec_pc + 4
//  irq_ack       out  1     one-cycle pulse: interrupt taken
//  in_irq        out  1     handler active; further interrupts masked
// BEHAVIOUR
//  Reset (async): fetch_pc=resp_pc=RESET_VEC; queue, outstanding, drop_cnt, epc=0; in_irq=0;
//   imem_req=0, dec_valid=0, dec_instr=NOP_INSTR, dec_pc=RESET_VEC, irq_ack=0.
//   imem must be reset with this block; no pre-reset response may arrive after release.
//  Issue: imem_req=1 iff (count+outstanding)<DEPTH and no redirect this cycle;
//   imem_addr=fetch_pc; fetch_pc+=4 per issue. Invariant: count+outstanding<=DEPTH.
//  Response: rvalid with drop_cnt==0 -> push {rdata, resp_pc}; resp_pc+=4. With drop_cnt>0
//   -> discard, drop_cnt-=1. Push never overflows (guaranteed by issue rule).
//  Output: registered-free head view: dec_valid=(count>0); dec_instr/dec_pc from head.
//   Pop when dec_valid&dec_ready. dec_ready=0 holds outputs stable. Min latency issue->dec_valid:
//   response cycle +1. Sustained 1 instr/clk when imem returns every cycle.
//  Redirect (priority interrupt-taken > rti > branch; one target chosen):
//   target = IRQ_VEC | epc | branch_target. Same cycle: no issue; next edge: queue emptied,
//   fetch_pc=resp_pc=target, drop_cnt=outstanding-(rvalid&&drop_cnt==0 ? 1:0)+drop_cnt adj,
//   i.e. every in-flight response is discarded; outstanding keeps counting to zero.
//   dec_valid forced 0 in the redirect cycle (acts as flush).
//  Interrupt taken = interrupt & ~in_irq. Then: irq_ack=1 next cycle, in_irq=1,
//   epc = branch ? branch_target : (count>0 ? head pc : resp_pc). A pop in the same cycle is
//   still delivered; epc then = PC after popped instruction. interrupt while in_irq: ignored.
//  rti: redirect to epc, in_irq=0. rsi: epc=0, in_irq=0; rsi wins over interrupt same cycle
//   (interrupt not taken). rti+rsi together: rti redirect, then epc=0.
//  Arithmetic: PCs wrap modulo 2^XLEN; counters $clog2(DEPTH)+1 bits.
// TESTING
//  1 Reset, imem latency 1, dec_ready=1 -> dec_pc 0,4,8,.. one per clk; imem_req never exceeds DEPTH outstanding.
//  2 imem latency 3, dec_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, outputs frozen, no loss on release.
//  3 branch to 0x100 with 3 in flight -> 3 stale responses dropped; next dec_pc=0x100, 0x104.
//  4 interrupt while head pc=0x20 -> irq_ack pulse, dec_pc=0x4 next; rti -> dec_pc=0x20; second interrupt while in_irq ignored.
//  5 interrupt and branch(0x80) same cycle -> epc=0x80, PC=IRQ_VEC; rsi -> epc=0, in_irq=0.
//  6 rst_n asserted mid-burst (async, between edges) -> outputs at reset values immediately; fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch stage with prefetch queue and redirect handling
// Decouples PC generation from a variable-latency in-order imem port; feeds decode via valid/ready.
module fetch_prefetch_unit #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h00000000,
  parameter logic [31:0] IRQ_VEC   = 32'h00000004,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            interrupt,
  input  logic            rti,
  input  logic            rsi,
  input  logic            dec_ready,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_next,
  output logic            irq_ack,
  output logic            in_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count, outstanding, drop_cnt;
  logic [XLEN-1:0] fetch_pc, resp_pc, epc;
  logic            started;

  logic            take_irq, redirect, flush, has_head, push, pop;
  logic [XLEN-1:0] target, head_pc, irq_epc;
  logic [CW:0]     in_use;

  always_comb begin
    take_irq = interrupt & ~in_irq & ~rsi;
    redirect = take_irq | rti | branch;
    // An interrupt alone lets the head instruction retire; branch and rti squash it.
    flush    = rti | branch;
    if (take_irq)  target = XLEN'(IRQ_VEC);
    else if (rti)  target = epc;
    else           target = branch_target;
    has_head = (count != '0);
    head_pc  = q_pc[head];
    in_use   = {1'b0, count} + {1'b0, outstanding};
  end

  assign dec_valid   = has_head & ~flush;
  assign dec_instr   = dec_valid ? q_instr[head] : XLEN'(NOP_INSTR);
  assign dec_pc      = has_head ? head_pc : resp_pc;
  assign dec_pc_next = dec_pc + XLEN'(4);
  assign pop         = dec_valid & dec_ready;
  assign push        = imem_rvalid & (drop_cnt == '0) & ~redirect;
  assign imem_req    = started & ~redirect & (in_use < LIMIT);
  assign imem_addr   = fetch_pc;

  always_comb begin
    if (branch)        irq_epc = branch_target;
    else if (has_head) irq_epc = pop ? head_pc + XLEN'(4) : head_pc;
    else               irq_epc = resp_pc;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      fetch_pc    <= XLEN'(RESET_VEC);
      resp_pc     <= XLEN'(RESET_VEC);
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      epc         <= '0;
      in_irq      <= 1'b0;
      irq_ack     <= 1'b0;
    end else begin
      started     <= 1'b1;
      irq_ack     <= take_irq;
      outstanding <= outstanding + CW'(imem_req) - CW'(imem_rvalid);
      if (redirect) begin
        // Every response still in flight after this edge belongs to the old stream.
        fetch_pc <= target;
        resp_pc  <= target;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) begin
          resp_pc <= resp_pc + XLEN'(4);
          tail    <= tail + AW'(1);
        end
        if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (take_irq) begin
        in_irq <= 1'b1;
        epc    <= irq_epc;
      end else begin
        if (rti | rsi) in_irq <= 1'b0;
        if (rsi)       epc    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - scoreboard bench for fetch_prefetch_unit
// Expected PC stream is derived from redirect rules; an in-order imem model supplies data.
module tb_fetch_prefetch_unit;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] IRQ_VEC   = 32'h4;
  localparam logic [31:0] NOP       = 32'h13;

  logic        clk, rst_n;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        branch, interrupt, rti, rsi, dec_ready;
  logic [31:0] branch_target;
  logic        dec_valid, irq_ack, in_irq;
  logic [31:0] dec_instr, dec_pc, dec_pc_next;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC), .IRQ_VEC(IRQ_VEC),
                        .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .branch(branch),
    .branch_target(branch_target), .interrupt(interrupt), .rti(rti), .rsi(rsi),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_pc_next(dec_pc_next), .irq_ack(irq_ack), .in_irq(in_irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, fire_cnt = 0, req_cnt = 0;
  int lat_min = 1, lat_max = 1, last_due = 0;

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t pend[$];
  req_t rq;
  logic [31:0] exp_q[$];
  logic [31:0] e_pc;
  logic        m_in_irq = 1'b0, p_in_irq = 1'b0, m_flush = 1'b0;
  logic [31:0] m_epc = '0, p_epc = '0;
  int          ack_due = -1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_true(input string name, input bit ok, input int got);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: observed %0d (cycle %0d)", name, got, cyc);
    end
  endtask

  // imem model: in-order responses, each at least one cycle after its request
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_rvalid) rq = pend.pop_front();
      if (imem_req) begin
        rq.addr = imem_addr;
        rq.due  = cyc + $urandom_range(lat_min, lat_max);
        if (rq.due <= last_due) rq.due = last_due + 1;
        last_due = rq.due;
        pend.push_back(rq);
        req_cnt++;
      end
      check_true("outstanding_bound", pend.size() <= DEPTH, pend.size());
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Monitor: compares every delivered instruction with the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_flush) check("flush_valid", 32'(dec_valid), 32'd0);
      check("irq_ack", 32'(irq_ack), 32'(cyc == ack_due));
      check("in_irq", 32'(in_irq), 32'(m_in_irq));
      if (dec_valid) begin
        check("dec_instr", dec_instr, instr_of(dec_pc));
        check("dec_pc_next", dec_pc_next, dec_pc + 32'd4);
      end else begin
        check("nop_instr", dec_instr, NOP);
      end
      if (dec_valid && dec_ready) begin
        fire_cnt++;
        if (exp_q.size() == 0) check_true("scoreboard_empty", 1'b0, 0);
        else begin
          e_pc = exp_q.pop_front();
          check("dec_pc", dec_pc, e_pc);
        end
      end
    end
  end

  task automatic step(input logic b_br, input logic [31:0] b_tgt, input logic b_irq,
                      input logic b_rti, input logic b_rsi, input logic b_rdy);
    logic take, deliver;
    logic [31:0] target, keep;
    @(posedge clk);
    #1;
    m_in_irq = p_in_irq;
    m_epc    = p_epc;
    branch = b_br; branch_target = b_tgt; interrupt = b_irq;
    rti = b_rti; rsi = b_rsi; dec_ready = b_rdy;
    take    = b_irq && !m_in_irq && !b_rsi;
    deliver = take && b_rdy && !b_br && !b_rti;
    m_flush = b_br || b_rti;
    if (take) begin
      ack_due  = cyc + 1;
      p_in_irq = 1'b1;
      p_epc    = b_br ? b_tgt : (deliver ? exp_q[0] + 32'd4 : exp_q[0]);
      target   = IRQ_VEC;
    end else begin
      target = b_rti ? m_epc : b_tgt;
      if (b_rti || b_rsi) p_in_irq = 1'b0;
      if (b_rsi) p_epc = '0;
    end
    if (take || b_rti || b_br) begin
      keep = exp_q[0];
      exp_q.delete();
      if (deliver) exp_q.push_back(keep);
      exp_q.push_back(target);
    end
    while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    branch = 1'b0; interrupt = 1'b0; rti = 1'b0; rsi = 1'b0; dec_ready = 1'b0;
    pend.delete();
    #1;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_irq_ack", 32'(irq_ack), 32'd0);
    check("rst_in_irq", 32'(in_irq), 32'd0);
    check("rst_dec_instr", dec_instr, NOP);
    check("rst_dec_pc", dec_pc, RESET_VEC);
    exp_q.delete();
    exp_q.push_back(RESET_VEC);
    m_in_irq = 1'b0; p_in_irq = 1'b0; m_epc = '0; p_epc = '0; m_flush = 1'b0; ack_due = -1;
    last_due = 0;
    idle(2, 1'b0);
    m_flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_cnt = 0;
  endtask

  int f0, k;
  logic [31:0] tgt;
  int r;

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    branch = 1'b0; branch_target = '0; interrupt = 1'b0; rti = 1'b0; rsi = 1'b0; dec_ready = 1'b0;

    // latency 1, decode always ready: one instruction per clock
    lat_min = 1; lat_max = 1;
    do_reset();
    f0 = fire_cnt;
    idle(30, 1'b1);
    check_true("throughput", (fire_cnt - f0) >= 26, fire_cnt - f0);

    // latency 3 with decode stalled: queue fills to DEPTH and holds
    lat_min = 3; lat_max = 3;
    do_reset();
    idle(10, 1'b0);
    @(negedge clk); #1;
    check("stall_req_cnt", 32'(req_cnt), 32'(DEPTH));
    check("stall_valid", 32'(dec_valid), 32'd1);
    check("stall_pc", dec_pc, RESET_VEC);
    idle(20, 1'b1);

    // branch with three responses in flight
    k = 0;
    while (pend.size() < 3 && k < 20) begin idle(1, 1'b1); k++; end
    check_true("inflight_3", pend.size() >= 3, pend.size());
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(12, 1'b1);

    // interrupt with head at 0x20, masked second interrupt, rti back to 0x20
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(8, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);

    // interrupt on a full queue while decode pops: head still delivered
    idle(8, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(6, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);

    // interrupt and branch together, then rsi clears epc
    step(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);

    // randomized traffic with a mid-burst asynchronous reset
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      r = $urandom_range(0, 99);
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if (r < 4)       step(1'b1, tgt, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      else if (r < 7)  step(1'($urandom_range(0, 1)), tgt, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (r < 9)  step(1'b0, '0, 1'b0, m_in_irq || p_in_irq, 1'($urandom_range(0, 1)), 1'b1);
      else if (r < 11) step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
      else             step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0));
    end
    idle(10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end
endmodule
